// File: rtl/board_ram_arbiter_if.sv
// Avalon-MM requester bundle used for both the host and the engine side of
// the board RAM arbiter. Each requester holds its request until it sees
// waitrequest=0, then gets read data back one cycle later.
//
// Handshake: a request (read or write) is accepted in the cycle where it is
// asserted and waitrequest is low. Read data arrives exactly one cycle later,
// qualified by readdatavalid. Reads may be issued back to back, one per
// accepted cycle, and data returns in issue order.
//
// Signals:
//   address        word address
//   read / write   request strobes (write wins if both are set)
//   writedata      write data
//   byteenable     byte lanes for writes
//   waitrequest    request not accepted this cycle
//   readdata       read data, zero unless readdatavalid
//   readdatavalid  readdata valid this cycle
//
// Modports: master = requester side, slave = arbiter side.
interface board_ram_arbiter_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 15
);
  logic [ADDR_WIDTH-1:0]   address;
  logic                    read;
  logic                    write;
  logic [DATA_WIDTH-1:0]   writedata;
  logic [DATA_WIDTH/8-1:0] byteenable;
  logic                    waitrequest;
  logic [DATA_WIDTH-1:0]   readdata;
  logic                    readdatavalid;

  modport master (
    output address, read, write, writedata, byteenable,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, read, write, writedata, byteenable,
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/board_ram_arbiter.sv
// board_ram_arbiter: shares the single-port board/control RAM between the
// host control slave and the search engine master. One access per cycle,
// round-robin on ties, waitrequest backpressure to the losing side and
// read-data routing back to whichever side issued the read. A saturating
// counter records cycles in which both sides were requesting.
//
// Optional feature (macro BOARD_ARB_LOCK_EN): adds input e_lock. When the
// engine won the previous grant and holds e_lock=1, the host is held off so
// the engine can perform an atomic read-modify-write.
//
// Ports:
//   clk             system clock
//   reset           synchronous, active-low reset
//   h               host requester (board_ram_arbiter_if.slave)
//   e               engine requester (board_ram_arbiter_if.slave)
//   e_lock          engine lock request (only with BOARD_ARB_LOCK_EN)
//   ram_address     RAM word address
//   ram_wren        RAM write enable
//   ram_byteenable  RAM byte enables
//   ram_writedata   RAM write data
//   ram_readdata    RAM read data, registered, 1-cycle latency
//   conflict_count  saturating count of contended cycles
module board_ram_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 15,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  board_ram_arbiter_if.slave      h,
  board_ram_arbiter_if.slave      e,
`ifdef BOARD_ARB_LOCK_EN
  input  logic                    e_lock,
`endif
  output logic [ADDR_WIDTH-1:0]   ram_address,
  output logic                    ram_wren,
  output logic [DATA_WIDTH/8-1:0] ram_byteenable,
  output logic [DATA_WIDTH-1:0]   ram_writedata,
  input  logic [DATA_WIDTH-1:0]   ram_readdata,
  output logic [CNT_WIDTH-1:0]    conflict_count
);

  typedef enum logic {WIN_HOST = 1'b0, WIN_ENGINE = 1'b1} win_t;

  win_t last_win;
  logic rd_valid;
  win_t rd_who;

  logic h_req, e_req;
  logic h_grant, e_grant;
  logic lock_active;
  logic rd_accept;

  assign h_req = h.read | h.write;
  assign e_req = e.read | e.write;

`ifdef BOARD_ARB_LOCK_EN
  // Lock only holds if the engine already owns the RAM; a fresh e_lock
  // cannot pre-empt a host that won the last grant.
  assign lock_active = e_lock & (last_win == WIN_ENGINE);
`else
  assign lock_active = 1'b0;
`endif

  // Host wins when alone, or on a tie when the engine won last time.
  assign h_grant = h_req & ~lock_active & (~e_req | (last_win == WIN_ENGINE));
  assign e_grant = e_req & ~h_grant;

  assign h.waitrequest = h_req & ~h_grant;
  assign e.waitrequest = e_req & ~e_grant;

  // RAM side is forced idle while reset is held so nothing is written or
  // queued for return during reset.
  always_comb begin
    ram_address    = '0;
    ram_wren       = 1'b0;
    ram_byteenable = '0;
    ram_writedata  = '0;
    rd_accept      = 1'b0;
    if (reset) begin
      if (h_grant) begin
        ram_address = h.address;
        ram_wren    = h.write;
        rd_accept   = ~h.write;
        if (h.write) begin
          ram_byteenable = h.byteenable;
          ram_writedata  = h.writedata;
        end
      end else if (e_grant) begin
        ram_address = e.address;
        ram_wren    = e.write;
        rd_accept   = ~e.write;
        if (e.write) begin
          ram_byteenable = e.byteenable;
          ram_writedata  = e.writedata;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      last_win       <= WIN_ENGINE;
      rd_valid       <= 1'b0;
      rd_who         <= WIN_HOST;
      conflict_count <= '0;
    end else begin
      if (h_grant | e_grant)
        last_win <= e_grant ? WIN_ENGINE : WIN_HOST;
      rd_valid <= rd_accept;
      if (rd_accept)
        rd_who <= e_grant ? WIN_ENGINE : WIN_HOST;
      if (h_req & e_req & (conflict_count != {CNT_WIDTH{1'b1}}))
        conflict_count <= conflict_count + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

  // Gated with reset so a return in flight is dropped as soon as reset is seen.
  assign h.readdatavalid = reset & rd_valid & (rd_who == WIN_HOST);
  assign e.readdatavalid = reset & rd_valid & (rd_who == WIN_ENGINE);
  assign h.readdata      = h.readdatavalid ? ram_readdata : '0;
  assign e.readdata      = e.readdatavalid ? ram_readdata : '0;

endmodule

// File: tb/tb_board_ram_arbiter.sv
// Testbench for board_ram_arbiter: directed steps followed by a randomized
// phase, all checked against a transaction-level reference model (who should
// win each cycle, a word memory, a queue of expected read returns and a
// contention count).
module tb_board_ram_arbiter;
  localparam int DW = 32;
  localparam int AW = 15;
  localparam int BW = DW / 8;
  localparam int CW = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  board_ram_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) h_bus ();
  board_ram_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) e_bus ();

  logic [AW-1:0] ram_address;
  logic          ram_wren;
  logic [BW-1:0] ram_byteenable;
  logic [DW-1:0] ram_writedata;
  logic [DW-1:0] ram_readdata;
  logic [CW-1:0] conflict_count;
  logic          e_lock = 1'b0;

  board_ram_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .clk            (clk),
    .reset          (reset),
    .h              (h_bus),
    .e              (e_bus),
`ifdef BOARD_ARB_LOCK_EN
    .e_lock         (e_lock),
`endif
    .ram_address    (ram_address),
    .ram_wren       (ram_wren),
    .ram_byteenable (ram_byteenable),
    .ram_writedata  (ram_writedata),
    .ram_readdata   (ram_readdata),
    .conflict_count (conflict_count)
  );

  // Bench-side RAM: registered read, byte-lane writes.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (ram_wren)
      for (int i = 0; i < BW; i++)
        if (ram_byteenable[i]) mem[ram_address][i*8 +: 8] <= ram_writedata[i*8 +: 8];
    ram_readdata <= mem[ram_address];
  end

  // ---------------- reference model / scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [DW-1:0] ref_mem [int];
  logic [DW-1:0] exp_q[$];
  bit            who_q[$];     // 1 = engine issued the read
  bit            m_engine_last = 1'b1;
  int            m_cnt = 0;
  bit            obs_hg, obs_eg, m_hg, m_eg;
  logic [DW-1:0] last_h_data;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] ref_read(input int a);
    return ref_mem.exists(a) ? ref_mem[a] : '0;
  endfunction

  function automatic void ref_write(input int a, input logic [DW-1:0] d, input logic [BW-1:0] be);
    logic [DW-1:0] w;
    w = ref_read(a);
    for (int i = 0; i < BW; i++)
      if (be[i]) w[i*8 +: 8] = d[i*8 +: 8];
    ref_mem[a] = w;
  endfunction

  // One clock cycle: inputs are already applied; check at the falling edge,
  // advance the model, then move to just after the next rising edge.
  task automatic cycle();
    bit hr, er, lock, hv, ev;
    logic [DW-1:0] hd, ed, eaddr;
    @(negedge clk);
    hr = h_bus.read | h_bus.write;
    er = e_bus.read | e_bus.write;
    lock = 1'b0;
`ifdef BOARD_ARB_LOCK_EN
    lock = e_lock && m_engine_last;
`endif
    m_hg = hr && !lock && (!er || m_engine_last);
    m_eg = er && !m_hg;
    obs_hg = hr && !h_bus.waitrequest;
    obs_eg = er && !e_bus.waitrequest;
    check("h_waitrequest", h_bus.waitrequest, hr && !m_hg);
    check("e_waitrequest", e_bus.waitrequest, er && !m_eg);

    hv = 0; ev = 0; hd = '0; ed = '0;
    if (exp_q.size() > 0) begin
      if (who_q[0]) begin ev = reset; ed = reset ? exp_q[0] : '0; end
      else begin hv = reset; hd = reset ? exp_q[0] : '0; end
      void'(exp_q.pop_front());
      void'(who_q.pop_front());
    end
    check("h_readdatavalid", h_bus.readdatavalid, hv);
    check("e_readdatavalid", e_bus.readdatavalid, ev);
    check("h_readdata", h_bus.readdata, hd);
    check("e_readdata", e_bus.readdata, ed);
    if (h_bus.readdatavalid) last_h_data = h_bus.readdata;
    check("conflict_count", conflict_count, m_cnt);

    eaddr = '0;
    if (reset && m_hg) eaddr = h_bus.address;
    else if (reset && m_eg) eaddr = e_bus.address;
    check("ram_address", ram_address, eaddr);
    check("ram_wren", ram_wren, reset && ((m_hg && h_bus.write) || (m_eg && e_bus.write)));

    if (!reset) begin
      m_engine_last = 1'b1;
      m_cnt = 0;
      exp_q.delete();
      who_q.delete();
    end else begin
      if (hr && er && m_cnt < CNT_MAX) m_cnt++;
      if (m_hg || m_eg) m_engine_last = m_eg;
      if (m_hg) begin
        if (h_bus.write) ref_write(int'(h_bus.address), h_bus.writedata, h_bus.byteenable);
        else begin exp_q.push_back(ref_read(int'(h_bus.address))); who_q.push_back(1'b0); end
      end else if (m_eg) begin
        if (e_bus.write) ref_write(int'(e_bus.address), e_bus.writedata, e_bus.byteenable);
        else begin exp_q.push_back(ref_read(int'(e_bus.address))); who_q.push_back(1'b1); end
      end
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- driver tasks ----------------
  task automatic h_set(input bit rd, input bit wr, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [BW-1:0] be);
    h_bus.read = rd; h_bus.write = wr; h_bus.address = a;
    h_bus.writedata = d; h_bus.byteenable = be;
  endtask

  task automatic e_set(input bit rd, input bit wr, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [BW-1:0] be);
    e_bus.read = rd; e_bus.write = wr; e_bus.address = a;
    e_bus.writedata = d; e_bus.byteenable = be;
  endtask

  task automatic idle_all();
    h_set(0, 0, '0, '0, '0);
    e_set(0, 0, '0, '0, '0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit h_pend, e_pend;
    int op;
    last_h_data = '0;
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    idle_all();
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Reset with no requests.
    cycle();
    cycle();
    reset = 1'b1;

    // Host write then read back.
    h_set(0, 1, 15'h0010, 32'hDEADBEEF, 4'hF);
    cycle();
    h_set(1, 0, 15'h0010, '0, '0);
    cycle();
    check("t2_read_accepted", obs_hg, 1);
    idle_all();
    cycle();
    check("t2_read_data", last_h_data, 32'hDEADBEEF);

    // Both read every cycle after reset: H,E,H,E,H,E.
    reset = 1'b0;
    cycle();
    reset = 1'b1;
    h_set(1, 0, 15'h0010, '0, '0);
    e_set(1, 0, 15'h0020, '0, '0);
    for (int i = 0; i < 6; i++) begin
      cycle();
      check("t3_host_grant", obs_hg, (i % 2) == 0);
      check("t3_engine_grant", obs_eg, (i % 2) == 1);
    end
    check("t3_conflicts", conflict_count, 6);
    idle_all();
    cycle();

    // Top address and byte lanes.
    h_set(0, 1, 15'h7FFF, 32'hFFFFFFFF, 4'hF);
    cycle();
    h_set(0, 1, 15'h7FFF, 32'h12345678, 4'h3);
    cycle();
    h_set(1, 0, 15'h7FFF, '0, '0);
    cycle();
    idle_all();
    cycle();
    check("t4_byte_lanes", last_h_data, 32'hFFFF5678);

    // Reset right after an accepted host read cancels the return.
    h_set(1, 0, 15'h7FFF, '0, '0);
    cycle();
    idle_all();
    reset = 1'b0;
    cycle();
    reset = 1'b1;
    cycle();
    h_set(1, 0, 15'h0001, '0, '0);
    e_set(1, 0, 15'h0002, '0, '0);
    cycle();
    check("t5_first_tie_host", obs_hg, 1);

`ifdef BOARD_ARB_LOCK_EN
    // Engine takes the RAM, then locks it against a waiting host.
    h_set(0, 0, '0, '0, '0);
    cycle();
    check("t6_engine_wins", obs_eg, 1);
    e_set(0, 0, '0, '0, '0);
    e_lock = 1'b1;
    h_set(1, 0, 15'h0010, '0, '0);
    for (int i = 0; i < 4; i++) begin
      cycle();
      check("t6_host_held", h_bus.waitrequest, 1);
    end
    e_lock = 1'b0;
    cycle();
    check("t6_host_after_unlock", obs_hg, 1);
`else
    // Without lock: strict alternation, host won last.
    for (int i = 0; i < 4; i++) begin
      cycle();
      check("t6_alternate", obs_hg, (i % 2) == 1);
    end
`endif
    idle_all();
    cycle();

    // Randomized traffic; requesters hold inputs until accepted.
    h_pend = 0;
    e_pend = 0;
    for (int n = 0; n < 400; n++) begin
      reset = ($urandom_range(0, 59) != 0);
      if (!h_pend) begin
        op = $urandom_range(0, 3);
        h_set(op[0], op[1], 15'($urandom_range(0, 15)), $urandom, 4'($urandom_range(0, 15)));
        h_pend = (op != 0);
      end
      if (!e_pend) begin
        op = $urandom_range(0, 3);
        e_set(op[0], op[1], 15'($urandom_range(0, 15)), $urandom, 4'($urandom_range(0, 15)));
        e_pend = (op != 0);
      end
`ifdef BOARD_ARB_LOCK_EN
      e_lock = ($urandom_range(0, 3) == 0);
`endif
      cycle();
      if (obs_hg) h_pend = 0;
      if (obs_eg) e_pend = 0;
    end
    reset = 1'b1;
    e_lock = 1'b0;

    // Saturation of the contention counter.
    h_set(1, 0, 15'h0003, '0, '0);
    e_set(1, 0, 15'h0004, '0, '0);
    for (int i = 0; i < CNT_MAX + 5; i++) cycle();
    check("saturated_count", conflict_count, CNT_MAX);
    idle_all();
    cycle();
    cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
